// File: rtl/shifter_right_seq.sv
// Iterative right shifter (logical/arithmetic) behind valid/ready handshakes.
// Latency: out_valid rises shamt edges after accept (stride build: shamt/4 + shamt%4).
// Backpressure: result is held in DONE until out_ready; in_ready is low while busy.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake carrying in_data, in_shamt, in_arith
//   out_valid/out_ready - result handshake carrying out_data
//
// Optional feature: define SHIFTER_RIGHT_STRIDE4_EN to shift by 4 per cycle
// while at least 4 positions remain (requires N >= 4). Results are identical
// in both builds; only latency differs.
module shifter_right_seq #(
  parameter int N = 32,
  parameter int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_shamt,
  input  logic         in_arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] work, work_nxt;
  logic [S-1:0] count, count_nxt;
  logic         fill, fill_nxt;

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    count_nxt = count;
    fill_nxt  = fill;

    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nxt  = in_data;
          count_nxt = in_shamt;
          // Sign is captured once here and never re-sampled while shifting.
          fill_nxt  = in_arith & in_data[N-1];
          state_nxt = (in_shamt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
`ifdef SHIFTER_RIGHT_STRIDE4_EN
        if (count > S'(3)) begin
          work_nxt  = {{4{fill}}, work[N-1:4]};
          count_nxt = count - S'(4);
        end else begin
          work_nxt  = {fill, work[N-1:1]};
          count_nxt = count - S'(1);
        end
`else
        work_nxt  = {fill, work[N-1:1]};
        count_nxt = count - S'(1);
`endif
        // SHIFT is only entered with a non-zero count, so reaching zero
        // means the last step has just been taken.
        if (count_nxt == '0) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      fill  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      count <= count_nxt;
      fill  <= fill_nxt;
    end
  end

endmodule

// File: tb/tb_shifter_right_seq.sv
// Directed and random checks of shifter_right_seq: reset state, logical and
// arithmetic results, latency, back-pressure, mid-shift reset, handshake count.
module tb_shifter_right_seq;
  localparam int N = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic         in_arith;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shifter_right_seq #(.N(N), .S(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic int steps_of(input int s);
`ifdef SHIFTER_RIGHT_STRIDE4_EN
    return s / 4 + s % 4;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request and return just after its accept edge; inputs are
  // then scrambled to show they are ignored while busy.
  task automatic accept(input logic [N-1:0] d, input int sh, input logic ar);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = S'(sh);
    in_arith = ar;
    tick;
    in_valid = 1'b0;
    in_data  = ~d;
    in_shamt = ~S'(sh);
    in_arith = ~ar;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] d, input int sh,
                        input logic ar, input logic [N-1:0] exp, input int stall);
    int n;
    accept(d, sh, ar);
    wait_valid(n);
    chk({tag, "_lat"}, N'(n), N'(steps_of(sh)));
    chk({tag, "_dat"}, out_data, exp);
    repeat (stall) tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    // Exactly one output handshake: back to IDLE with no second valid.
    chk({tag, "_one"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic               seen;
    logic [N-1:0]       d, exp;
    logic signed [N-1:0] sd;
    int                 sh;
    logic               ar;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready},  1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data",  out_data, 32'h0000_0000);

    // Logical shift by 4.
    run_op("lsr4", 32'hF000_0001, 4, 1'b0, 32'h0F00_0000, 0);

    // Arithmetic vs logical shift of the sign bit by 31.
    run_op("asr31", 32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, 1);
    run_op("lsr31", 32'h8000_0000, 31, 1'b0, 32'h0000_0001, 0);

    // Stride-sensitive case.
    run_op("asr9", 32'hFFFF_0000, 9, 1'b1, 32'hFFFF_FF80, 2);
    run_op("asr1_pos", 32'h7FFF_FFFE, 1, 1'b1, 32'h3FFF_FFFF, 0);

    // Zero shift: valid right after accept, then held under back-pressure
    // while a new request is offered and must be ignored.
    accept(32'h1234_5678, 0, 1'b0);
    chk("zero_vld", {31'd0, out_valid}, 1);
    chk("zero_dat", out_data, 32'h1234_5678);
    in_valid = 1'b1;
    in_data  = 32'hAAAA_5555;
    in_shamt = 5'd3;
    in_arith = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_vld", {31'd0, out_valid}, 1);
      chk("bp_dat", out_data, 32'h1234_5678);
      chk("bp_rdy", {31'd0, in_ready}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    tick;
    chk("bp_ignored", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset in the middle of a long shift.
    accept(32'hDEAD_BEEF, 20, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_in_ready",  {31'd0, in_ready},  1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_out_data",  out_data, 32'h0000_0000);
    repeat (30) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_stale", {31'd0, seen}, 0);

    // Random regression against a >> / >>> golden model.
    for (int k = 0; k < 1000; k++) begin
      d  = $urandom;
      sh = $urandom_range(0, N - 1);
      ar = 1'($urandom_range(0, 1));
      sd = d;
      if (ar) begin
        exp = sd >>> sh;
      end else begin
        exp = d >> sh;
      end
      run_op("rand", d, sh, ar, exp, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter_right_seq.md
# shifter_right_seq

Iterative right shifter: accepts an N-bit operand, shift amount and mode over a valid/ready handshake, then shifts right (logical or arithmetic) over several cycles. It is the right-shift, multi-cycle counterpart to the ALU's combinational left shifters. It serves ALU SRL/SRA operations where area matters more than latency. Output is presented on a second valid/ready handshake.

## Interface
- `N`, default 32: operand width; must be ≥ 2.
- `S`, default $clog2(N): shift-amount width.

Ports, clock and reset first:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  N  operand.
- `in_shamt`  in  S  shift amount, 0..N-1.
- `in_arith`  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  N  shifted result.

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `in_data` into the work register; latch `in_shamt` into the count; latch the fill bit (`in_arith ? in_data[N-1] : 0`).
  - Go to DONE if `in_shamt` == 0, else go to SHIFT.
- SHIFT:
  - Each cycle, the work register becomes `{fill, work[N-1:1]}` and the count decrements by 1.
  - When the count goes from 1 to 0, go to DONE.
- DONE:
  - `out_valid` = 1 and `out_data` = work register, both held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE. Both are decoded directly from the state register.
- `out_data` is the work register at all times; it is only meaningful while `out_valid` = 1.
- Inputs are ignored outside IDLE. Changes to `in_*` during SHIFT or DONE have no effect.
- The fill bit is fixed at accept time. The sign is never re-sampled during shifting.
- Reset mid-operation: the state returns to IDLE and the in-flight result is discarded; no `out_valid` pulse is produced.

## Timing
- Reset values:
  - state IDLE, work register 0, count 0, fill 0.
  - Therefore after the reset edge: `in_ready` = 1, `out_valid` = 0, `out_data` = 0.
- Latency: accept on edge E0, and `out_valid` rises after edge E0 + steps, where:
  - steps = `in_shamt` without the stride feature;
  - `in_shamt` = 0 gives `out_valid` on the cycle right after accept.
- Minimum occupancy per request is steps + 2 cycles, with `out_ready` held high. There is no back-to-back accept in the cycle the result is consumed.
- `out_valid` never drops without a handshake, except on reset.
- `rst` takes priority over every handshake in the same cycle.

## Configuration
- Macro: `SHIFTER_RIGHT_STRIDE4_EN`.
- Defined:
  - In SHIFT, when count ≥ 4, shift by 4 in one cycle (`{4{fill}}` concatenated with `work[N-1:4]`) and subtract 4 from the count.
  - Otherwise shift by 1, as above.
  - steps = floor(shamt/4) + (shamt mod 4).
  - Requires N ≥ 4.
- Undefined: single-bit stride only; steps = shamt.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- Logical shift, no stride: `rst` pulse, then `in_data`=0xF000_0001, `in_shamt`=4, `in_arith`=0 → `out_data`=0x0F00_0000, with `out_valid` rising 4 edges after the accept edge.
- Arithmetic shift: `in_data`=0x8000_0000, `in_shamt`=31, `in_arith`=1 → `out_data`=0xFFFF_FFFF. The same operand with `in_arith`=0 → 0x0000_0001.
- Zero shift and back-pressure: `in_data`=0x1234_5678, `in_shamt`=0 → `out_valid` on the next cycle. Hold `out_ready`=0 for 5 cycles → `out_valid` and `out_data` stay stable, `in_ready`=0, and a new `in_valid` is ignored. Release → IDLE, `in_ready`=1.
- Reset mid-shift: accept `in_shamt`=20, assert `rst` on cycle 6 → the next cycle shows `in_ready`=1, `out_valid`=0, `out_data`=0, and no stale result ever appears.
- Stride build: with `SHIFTER_RIGHT_STRIDE4_EN`, `in_data`=0xFFFF_0000, `in_shamt`=9, `in_arith`=1 → `out_data`=0xFFFF_FF80 after 3 steps. Without the macro, the same result after 9 steps.
- Random regression: 1000 random operand/shamt/mode triples with random `out_ready` stalls → every result matches a `>>` / `>>>` golden model, and each accepted request produces exactly one output handshake.
